// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that puts the I-side miss port and the D-side port onto one memory port.
// It holds one transaction at a time and drops the completion strobe of transactions cancelled by a flush.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          flush,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [3:0]    d_sel,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          m_access,
  output logic          m_write,
  output logic [1:0]    m_size,
  output logic [3:0]    m_sel,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          grant_i,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t state;
  logic   last_d;
  logic   abort;
  logic   d_live;
  logic   pick_d;

  // A flush in IDLE kills only the D-side request; instruction fetch proceeds.
  assign d_live = d_req & ~flush;
  assign pick_d = d_live & (~i_req | ~last_d);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      abort   <= 1'b0;
      m_write <= 1'b0;
      m_size  <= '0;
      m_sel   <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state   <= D_BUSY;
            m_write <= d_wr;
            m_size  <= d_size;
            m_sel   <= d_sel;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (i_req) begin
            state   <= I_BUSY;
            m_write <= 1'b0;
            m_size  <= 2'b10;
            m_sel   <= 4'b1111;
            m_addr  <= i_addr;
          end
        end
        default: begin
          // The bus beat cannot be cancelled, so a flush only marks it for a silent finish.
          if (flush) abort <= 1'b1;
          if (m_ready) begin
            state  <= IDLE;
            last_d <= (state == D_BUSY);
            abort  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign m_access = (state != IDLE);
  assign busy     = (state != IDLE);
  assign grant_i  = (state == I_BUSY) | ((state == IDLE) & ~last_d);
  assign i_ready  = (state == I_BUSY) & m_ready & ~abort & ~flush;
  assign d_ready  = (state == D_BUSY) & m_ready & ~abort & ~flush;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          flush;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wr;
  logic [1:0]    d_size;
  logic [3:0]    d_sel;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          m_access, m_write;
  logic [1:0]    m_size;
  logic [3:0]    m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          grant_i, busy;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_access(m_access), .m_write(m_write), .m_size(m_size), .m_sel(m_sel),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
    .grant_i(grant_i), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_size = '0;
    d_sel = '0; d_addr = '0; d_wdata = '0; m_ready = 0; m_rdata = '0;
  endtask

  task automatic do_reset;
    aresetn = 0;
    idle_inputs();
    repeat (2) @(posedge aclk);
    #3 aresetn = 1;
    step();
  endtask

  task automatic test_reset;
    aresetn = 0;
    idle_inputs();
    #7;
    vectors++;
    if ({m_access, m_write, m_size, m_sel, busy, grant_i, i_ready, d_ready} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {m_access, m_write, m_size, m_sel, busy, grant_i, i_ready, d_ready});
    end
    vectors++;
    if ({m_addr, m_wdata} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {m_addr, m_wdata});
    end
    @(posedge aclk); #3 aresetn = 1;
    step();
    vectors++;
    if ({busy, grant_i} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got busy/grant_i %b want 00", {busy, grant_i});
    end
  endtask

  task automatic test_i_fetch;
    int acc = 0;
    i_req = 1; i_addr = 32'hBFC00000;
    step();
    acc += m_access;
    vectors++;
    if ({m_addr, m_sel, m_write, m_size, grant_i} !== {32'hBFC00000, 4'b1111, 1'b0, 2'b10, 1'b1}) begin
      miscompares++;
      $display("FAIL fetch_cmd: got addr %h sel %b wr %b sz %b gi %b", m_addr, m_sel, m_write, m_size, grant_i);
    end
    step(); acc += m_access;
    step(); acc += m_access;
    m_ready = 1; m_rdata = 32'h3C088000;
    #1;
    vectors++;
    if ({i_ready, d_ready, i_rdata} !== {2'b10, 32'h3C088000}) begin
      miscompares++;
      $display("FAIL fetch_ready: got %b/%b data %h want 1/0 3c088000", i_ready, d_ready, i_rdata);
    end
    step();
    m_ready = 0; i_req = 0;
    #1;
    vectors++;
    if ({i_ready, m_access, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL fetch_done: got ready/access/busy %b want 000", {i_ready, m_access, busy});
    end
    vectors++;
    if (acc !== 3) begin
      miscompares++;
      $display("FAIL fetch_len: got %0d access cycles want 3", acc);
    end
  endtask

  task automatic test_back_to_back;
    int gap = 0;
    do_reset();
    i_req = 1; i_addr = 32'h00001000;
    d_req = 1; d_wr = 1; d_size = 2'b10; d_sel = 4'b0011;
    d_addr = 32'h80001000; d_wdata = 32'h12345678;
    step();
    vectors++;
    if ({grant_i, m_write, m_addr} !== {2'b10, 32'h00001000}) begin
      miscompares++;
      $display("FAIL b2b_first: got gi %b wr %b addr %h want I fetch", grant_i, m_write, m_addr);
    end
    m_ready = 1;
    #1;
    vectors++;
    if ({i_ready, d_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_iready: got %b want 10", {i_ready, d_ready});
    end
    step();
    m_ready = 0; i_req = 0;
    while (!m_access && gap < 5) begin gap++; step(); end
    vectors++;
    if (gap !== 1) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d idle cycles want 1", gap);
    end
    vectors++;
    if ({m_write, m_sel, m_addr, m_wdata, grant_i} !== {1'b1, 4'b0011, 32'h80001000, 32'h12345678, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_store: got wr %b sel %b addr %h wd %h gi %b", m_write, m_sel, m_addr, m_wdata, grant_i);
    end
    m_ready = 1;
    #1;
    vectors++;
    if ({i_ready, d_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_dready: got %b want 01", {i_ready, d_ready});
    end
    step();
    m_ready = 0; d_req = 0;
    step();
  endtask

  task automatic test_round_robin;
    do_reset();
    i_req = 1; i_addr = 32'h100;
    step();
    m_ready = 1;
    step();
    m_ready = 0; i_req = 0;
    step();
    vectors++;
    if ({busy, grant_i} !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_idle: got busy/gi %b want 01", {busy, grant_i});
    end
    i_req = 1; d_req = 1; d_wr = 1; d_addr = 32'h200; d_sel = 4'b1000; d_size = 2'b00;
    step();
    vectors++;
    if ({grant_i, m_write, m_addr} !== {2'b01, 32'h200}) begin
      miscompares++;
      $display("FAIL rr_dwins: got gi %b wr %b addr %h want D after I", grant_i, m_write, m_addr);
    end
    m_ready = 1;
    step();
    m_ready = 0; d_req = 0;
    step();
    m_ready = 1;
    step();
    m_ready = 0; i_req = 0;
    step();
  endtask

  task automatic test_alternate;
    do_reset();
    i_req = 1; i_addr = 32'h40; d_req = 1; d_wr = 0; d_addr = 32'h80; d_sel = 4'hf; d_size = 2'b10;
    for (int t = 0; t < 4; t++) begin
      int w = 0;
      logic gi;
      while (!m_access && w < 10) begin step(); w++; end
      vectors++;
      if (!m_access) begin
        miscompares++;
        $display("FAIL alt_timeout: round %0d got no grant want grant", t);
      end
      gi = grant_i;
      vectors++;
      if (gi !== (t % 2 == 0)) begin
        miscompares++;
        $display("FAIL alt_order: round %0d got grant_i %b want %b", t, gi, (t % 2 == 0));
      end
      m_ready = 1;
      step();
      m_ready = 0;
      if (gi) i_req = 0; else d_req = 0;
      step();
      i_req = 1; d_req = 1;
    end
    i_req = 0; d_req = 0;
    repeat (2) begin m_ready = 1; step(); end
    m_ready = 0;
    step();
  endtask

  task automatic test_flush_abort;
    do_reset();
    d_req = 1; d_wr = 0; d_addr = 32'h3000; d_sel = 4'hf; d_size = 2'b10;
    step();
    step();
    flush = 1;
    step();
    flush = 0; m_ready = 1; m_rdata = 32'hDEAD0001;
    #1;
    vectors++;
    if ({d_ready, i_ready, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL abort_suppress: got dr/ir/busy %b want 001", {d_ready, i_ready, busy});
    end
    step();
    m_ready = 0; d_req = 0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy %b want 0", busy);
    end
    i_req = 1; i_addr = 32'h4000;
    step();
    vectors++;
    if ({m_access, grant_i, m_addr} !== {2'b11, 32'h4000}) begin
      miscompares++;
      $display("FAIL abort_next: got acc %b gi %b addr %h", m_access, grant_i, m_addr);
    end
    m_ready = 1;
    #1;
    vectors++;
    if (i_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_cleared: got i_ready %b want 1", i_ready);
    end
    step();
    m_ready = 0; i_req = 0;
    d_req = 1;
    step();
    flush = 1; m_ready = 1;
    #1;
    vectors++;
    if (d_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_same_cycle: got d_ready %b want 0", d_ready);
    end
    step();
    flush = 1; m_ready = 0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_return: got busy %b want 0", busy);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_d: got busy %b want 0", busy);
    end
    d_req = 0; i_req = 1; i_addr = 32'h5000;
    step();
    vectors++;
    if ({busy, grant_i} !== 2'b11) begin
      miscompares++;
      $display("FAIL flush_idle_i: got busy/gi %b want 11", {busy, grant_i});
    end
    flush = 0; m_ready = 1;
    step();
    m_ready = 0; i_req = 0;
    step();
  endtask

  task automatic test_reset_mid;
    d_req = 1; d_wr = 1; d_addr = 32'h6000; d_sel = 4'hf;
    step();
    #2 aresetn = 0;
    #1;
    vectors++;
    if ({m_access, busy, grant_i} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid: got acc/busy/gi %b want 000", {m_access, busy, grant_i});
    end
    d_req = 0;
    @(posedge aclk); #3 aresetn = 1;
    step();
    i_req = 1; d_req = 1;
    step();
    vectors++;
    if ({busy, grant_i, m_write} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_mid_pair: got busy/gi/wr %b want 110", {busy, grant_i, m_write});
    end
    m_ready = 1;
    step();
    m_ready = 0; i_req = 0;
    step();
    m_ready = 1;
    step();
    m_ready = 0; d_req = 0;
    step();
  endtask

  task automatic test_spurious;
    m_ready = 1;
    #1;
    vectors++;
    if ({i_ready, d_ready, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL spurious_strobe: got %b want 000", {i_ready, d_ready, busy});
    end
    step();
    m_ready = 0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_busy: got %b want 0", busy);
    end
  endtask

  // Reference: one outstanding transaction, owner and last served side tracked explicitly.
  task automatic test_random;
    bit ref_busy = 0, ref_owner_d = 0, ref_last_d = 1, ref_abort = 0;
    logic [AW+7:0] ref_cmd = '0;
    logic [DW-1:0] ref_wdata = '0;
    bit i_drop = 0, d_drop = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit e_ir, e_dr, e_gi, win_i, win_d;
      if (i_drop) begin i_req = 0; i_drop = 0; end
      else if (!i_req && $urandom_range(2) == 0) begin i_req = 1; i_addr = $urandom; end
      if (d_drop) begin d_req = 0; d_drop = 0; end
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_wr = $urandom; d_size = $urandom; d_sel = $urandom;
        d_addr = $urandom; d_wdata = $urandom;
      end
      flush = ($urandom_range(7) == 0);
      m_ready = ref_busy ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      m_rdata = $urandom;
      #1;
      e_gi = ref_busy ? !ref_owner_d : !ref_last_d;
      e_ir = ref_busy && !ref_owner_d && m_ready && !ref_abort && !flush;
      e_dr = ref_busy && ref_owner_d && m_ready && !ref_abort && !flush;
      vectors++;
      if ({m_access, busy, grant_i, i_ready, d_ready} !== {ref_busy, ref_busy, e_gi, e_ir, e_dr}) begin
        miscompares++;
        $display("FAIL rand_ctrl c%0d: got %b want %b", c, {m_access, busy, grant_i, i_ready, d_ready},
                 {ref_busy, ref_busy, e_gi, e_ir, e_dr});
      end
      if (ref_busy) begin
        vectors++;
        if ({m_write, m_size, m_sel, m_addr} !== ref_cmd || (ref_owner_d && m_wdata !== ref_wdata)) begin
          miscompares++;
          $display("FAIL rand_cmd c%0d: got %h/%h want %h/%h", c, {m_write, m_size, m_sel, m_addr}, m_wdata,
                   ref_cmd, ref_wdata);
        end
      end
      if (e_ir || e_dr) begin
        vectors++;
        if ((e_ir ? i_rdata : d_rdata) !== m_rdata) begin
          miscompares++;
          $display("FAIL rand_rdata c%0d: got %h want %h", c, e_ir ? i_rdata : d_rdata, m_rdata);
        end
      end
      if (e_ir) i_drop = 1;
      if (e_dr) d_drop = 1;
      if (ref_busy) begin
        if (flush) ref_abort = 1;
        if (m_ready) begin ref_busy = 0; ref_last_d = ref_owner_d; ref_abort = 0; end
      end else begin
        win_d = d_req && !flush && (!i_req || !ref_last_d);
        win_i = i_req && !win_d;
        if (win_d) begin
          ref_busy = 1; ref_owner_d = 1;
          ref_cmd = {d_wr, d_size, d_sel, d_addr}; ref_wdata = d_wdata;
        end else if (win_i) begin
          ref_busy = 1; ref_owner_d = 0;
          ref_cmd = {1'b0, 2'b10, 4'b1111, i_addr};
        end
      end
      step();
    end
    idle_inputs();
    repeat (2) begin m_ready = 1; step(); end
    m_ready = 0;
  endtask

  initial begin
    aresetn = 0;
    idle_inputs();
    test_reset();
    test_i_fetch();
    test_back_to_back();
    test_round_robin();
    test_alternate();
    test_flush_abort();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
